clock_ctrl: RTL and testbench
=============================

# clock_ctrl

User-interface sequencer for the digital clock datapath. Takes raw push-buttons and the power switch, debounces them, and drives the clock's `enable`, `add_time`, `sub_time` and `timing_clock_switch` inputs. Runs a mode state machine covering run, time-set and alarm-set, with auto-repeat on held buttons and an inactivity timeout. Sits between the board I/O and the clock core, replacing direct wiring of switches to the core.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to accept a button level change.
- `REPEAT_DELAY`, default 16: cycles a debounced up/down level must stay high before auto-repeat starts.
- `REPEAT_RATE`, default 4: cycles between auto-repeat pulses.
- `TIMEOUT`, default 256: idle cycles in a set state before forced return to RUN.
- `clk_src`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `power`  in  1  raw power switch level; synchronized, not debounced.
- `mode_btn`  in  1  raw mode button; asynchronous.
- `up_btn`  in  1  raw increment button; asynchronous.
- `down_btn`  in  1  raw decrement button; asynchronous.
- `enable`  out  1  clock core counting enable.
- `add_time`  out  3  one-cycle increment pulse, one-hot: [0] second, [1] minute, [2] hour.
- `sub_time`  out  3  one-cycle decrement pulse, same encoding.
- `timing_clock_switch`  out  1  high while add/sub are steered to the alarm register.
- `field_sel`  out  3  one-hot field being edited (display blink); 0 outside set states.
- `state`  out  3  current state encoding (debug).

## Operation
- States and encodings: OFF=0, RUN=1, SET_H=2, SET_M=3, SET_S=4, ALM_H=5, ALM_M=6. Encodings 7 and up are illegal and go to OFF.
- Synchronized power low: go to OFF from any state. This has priority over every other event.
- OFF to RUN: when synchronized power is high.
- Mode press event cycles RUN -> SET_H -> SET_M -> SET_S -> ALM_H -> ALM_M -> RUN. Ignored in OFF.
- Debounce, per button:
  - 2-flop synchronizer feeds a counter.
  - The counter increments each cycle the synchronized level differs from the debounced level, and clears on any cycle they match.
  - On the edge where the count reaches `DEBOUNCE_CYCLES`, the debounced level toggles and the counter clears.
  - A press event is a one-cycle pulse on the debounced rising edge.
- Up/down handling, in set states only:
  - Each press event emits one pulse on `add_time`/`sub_time` at the bit for the current field: SET_H/ALM_H hour, SET_M/ALM_M minute, SET_S second.
  - Auto-repeat: with the debounced level still high, the first repeat pulse fires `REPEAT_DELAY` cycles after the press pulse, then one every `REPEAT_RATE` cycles.
  - In OFF and RUN, up/down are ignored and outputs stay 0.
- Up and down both debounced high: no pulses, repeat counter held at 0. Pulses resume only on a fresh press event.
- Any state change clears the repeat counter. A button held across a mode change produces no pulses in the new state until it is re-pressed.
- Timeout: in SET_* or ALM_* states, the idle counter clears on any mode/up/down press event or repeat pulse. When it reaches `TIMEOUT`, go to RUN.
- Output decode (registered from the state):
  - `enable`=1 only in RUN.
  - `timing_clock_switch`=1 only in ALM_H/ALM_M.
  - `field_sel` is the one-hot field in set states, 0 otherwise.
- `add_time` and `sub_time` never have more than one bit set, and are never both nonzero in the same cycle.

## Timing
- Reset (reset_n=0, asynchronous):
  - state = OFF.
  - `enable`, `add_time`, `sub_time`, `timing_clock_switch`, `field_sel` all 0; `state` = 0.
  - Synchronizers, debounced levels and all counters = 0.
- Button latency: raw level first sampled at edge 1; debounced level changes at edge 2+`DEBOUNCE_CYCLES`. The press pulse or state change is visible after edge 3+`DEBOUNCE_CYCLES` and stays for exactly 1 cycle. With D=4, the pulse is high between edges 7 and 8.
- Power latency: state reaches OFF/RUN after edge 3 from first sample. Outputs update in the same cycle as the state.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronized cycles produce no event.
- Reset asserted mid-hold or mid-set: immediate return to reset values. After release with power high, RUN is reached after 3 edges.

## Test plan
- Reset then power=1 -> `state`=1 and `enable`=1 after 3rd edge; all pulse outputs 0 throughout.
- Mode pressed twice (held 10 cycles each, D=4) -> state 1->2->3; `enable` drops to 0 at the first transition; `field_sel` = 3'b100 then 3'b010.
- In SET_M, up held 40 cycles -> `add_time`=3'b010 pulses at offsets 0, 16, 20, 24, 28, 32, 36 relative to the first pulse, then stops within 1 cycle after the debounced release.
- In ALM_H, up and down pressed together -> no pulses; `timing_clock_switch`=1, `field_sel`=3'b100.
- In SET_S with no input for 256 cycles -> `state` returns to 1 and `enable`=1; a 3-cycle glitch on `mode_btn` produces no transition.
- In SET_H, power dropped -> `state`=0 after 3rd edge; up presses ignored; power restored -> RUN.

Source files
------------

// File: rtl/clock_ctrl.sv
// clock_ctrl: board-side front end for the digital clock core. Debounces the buttons,
// synchronises power, and runs the run/time-set/alarm-set mode machine with auto-repeat.
module clock_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 16,
  parameter int unsigned REPEAT_RATE     = 4,
  parameter int unsigned TIMEOUT         = 256
) (
  input  logic       clk_src,
  input  logic       reset_n,
  input  logic       power,
  input  logic       mode_btn,
  input  logic       up_btn,
  input  logic       down_btn,
  output logic       enable,
  output logic [2:0] add_time,
  output logic [2:0] sub_time,
  output logic       timing_clock_switch,
  output logic [2:0] field_sel,
  output logic [2:0] state
);
  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RptW  = $clog2(REPEAT_DELAY + 1);
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StOff  = 3'd0,
    StRun  = 3'd1,
    StSetH = 3'd2,
    StSetM = 3'd3,
    StSetS = 3'd4,
    StAlmH = 3'd5,
    StAlmM = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      sync1_q, sync2_q, db_q, db_prev_q;
  logic [DbW-1:0]  db_cnt_q [3];
  logic            pwr1_q, pwr2_q;
  logic            armed_q, armed_d, dir_q, dir_d;
  logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic [2:0]      add_d, sub_d, press, field;
  logic            set_st, stay, both, held, rpt_fire, activity, timeout;

  function automatic logic [2:0] field_of(state_e s);
    case (s)
      StSetH, StAlmH: field_of = 3'b100;
      StSetM, StAlmM: field_of = 3'b010;
      StSetS:         field_of = 3'b001;
      default:        field_of = 3'b000;
    endcase
  endfunction

  // Bit 0 mode, bit 1 up, bit 2 down.
  assign press = db_q & ~db_prev_q;
  assign state = state_q;

  always_ff @(posedge clk_src or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      pwr1_q    <= 1'b0;
      pwr2_q    <= 1'b0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= {down_btn, up_btn, mode_btn};
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      pwr1_q    <= power;
      pwr2_q    <= pwr1_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
          db_q[i]     <= ~db_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    set_st   = state_q inside {StSetH, StSetM, StSetS, StAlmH, StAlmM};
    field    = field_of(state_q);
    both     = db_q[1] & db_q[2];
    held     = dir_q ? db_q[2] : db_q[1];
    rpt_fire = armed_q & held & ~both & (rpt_cnt_q == RptW'(REPEAT_DELAY));
    activity = (|press) | rpt_fire;
    timeout  = set_st & ~activity & (idle_q == IdleW'(TIMEOUT - 1));
  end

  // Power loss outranks everything; mode press outranks the idle timeout.
  always_comb begin
    state_d = state_q;
    if (!pwr2_q) begin
      state_d = StOff;
    end else begin
      case (state_q)
        StOff:   state_d = StRun;
        StRun:   state_d = press[0] ? StSetH : StRun;
        StSetH:  state_d = press[0] ? StSetM : (timeout ? StRun : StSetH);
        StSetM:  state_d = press[0] ? StSetS : (timeout ? StRun : StSetM);
        StSetS:  state_d = press[0] ? StAlmH : (timeout ? StRun : StSetS);
        StAlmH:  state_d = press[0] ? StAlmM : (timeout ? StRun : StAlmH);
        StAlmM:  state_d = (press[0] || timeout) ? StRun : StAlmM;
        default: state_d = StOff;
      endcase
    end
    stay = (state_d == state_q);
  end

  // A held button only repeats after a press seen in the current state.
  always_comb begin
    add_d     = '0;
    sub_d     = '0;
    armed_d   = armed_q;
    dir_d     = dir_q;
    rpt_cnt_d = rpt_cnt_q;
    if (!set_st || !stay || both) begin
      armed_d   = 1'b0;
      rpt_cnt_d = '0;
    end else if (press[1]) begin
      add_d     = field;
      armed_d   = 1'b1;
      dir_d     = 1'b0;
      rpt_cnt_d = RptW'(1);
    end else if (press[2]) begin
      sub_d     = field;
      armed_d   = 1'b1;
      dir_d     = 1'b1;
      rpt_cnt_d = RptW'(1);
    end else if (armed_q && held) begin
      if (rpt_fire) begin
        if (dir_q) sub_d = field;
        else       add_d = field;
        rpt_cnt_d = RptW'(REPEAT_DELAY - REPEAT_RATE + 1);
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end else begin
      armed_d   = 1'b0;
      rpt_cnt_d = '0;
    end
    idle_d = (!set_st || !stay || activity) ? '0 : idle_q + 1'b1;
  end

  always_ff @(posedge clk_src or negedge reset_n) begin
    if (!reset_n) begin
      state_q             <= StOff;
      armed_q             <= 1'b0;
      dir_q               <= 1'b0;
      rpt_cnt_q           <= '0;
      idle_q              <= '0;
      enable              <= 1'b0;
      timing_clock_switch <= 1'b0;
      field_sel           <= '0;
      add_time            <= '0;
      sub_time            <= '0;
    end else begin
      state_q             <= state_d;
      armed_q             <= armed_d;
      dir_q               <= dir_d;
      rpt_cnt_q           <= rpt_cnt_d;
      idle_q              <= idle_d;
      enable              <= (state_d == StRun);
      timing_clock_switch <= state_d inside {StAlmH, StAlmM};
      field_sel           <= field_of(state_d);
      add_time            <= add_d;
      sub_time            <= sub_d;
    end
  end
endmodule

// File: tb/tb_clock_ctrl.sv
// tb_clock_ctrl: directed scenarios for clock_ctrl followed by randomized button and
// power activity checked cycle by cycle against a behavioural model of the UI rules.
module tb_clock_ctrl;
  localparam int D  = 4;
  localparam int RD = 16;
  localparam int RR = 4;
  localparam int TO = 256;

  logic       clk_src = 1'b0;
  logic       reset_n = 1'b0;
  logic       power = 1'b0, mode_btn = 1'b0, up_btn = 1'b0, down_btn = 1'b0;
  logic       enable, timing_clock_switch;
  logic [2:0] add_time, sub_time, field_sel, state;
  int         n_cmp = 0;
  int         n_fail = 0;

  clock_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .TIMEOUT        (TO)
  ) dut (
    .clk_src            (clk_src),
    .reset_n            (reset_n),
    .power              (power),
    .mode_btn           (mode_btn),
    .up_btn             (up_btn),
    .down_btn           (down_btn),
    .enable             (enable),
    .add_time           (add_time),
    .sub_time           (sub_time),
    .timing_clock_switch(timing_clock_switch),
    .field_sel          (field_sel),
    .state              (state)
  );

  always #5 clk_src = ~clk_src;

  // Behavioural model: edge count, raw-sample history, time of each debounced rise,
  // time of the last arming press and of the last user activity.
  int         m_n, m_st, m_rdir, m_t0, m_last;
  bit         m_psamp [2];
  bit         m_bsamp [3][2];
  bit         m_db [3];
  int         m_streak [3];
  int         m_rise [3];
  logic [2:0] e_add, e_sub;

  function automatic logic [2:0] fld_of(int s);
    case (s)
      2, 5:    fld_of = 3'b100;
      3, 6:    fld_of = 3'b010;
      4:       fld_of = 3'b001;
      default: fld_of = 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    m_n = 0; m_st = 0; m_rdir = 0; m_t0 = 0; m_last = 0; e_add = '0; e_sub = '0;
    m_psamp[0] = 0; m_psamp[1] = 0;
    for (int b = 0; b < 3; b++) begin
      m_db[b] = 0; m_streak[b] = 0; m_rise[b] = -100;
      m_bsamp[b][0] = 0; m_bsamp[b][1] = 0;
    end
  endtask

  task automatic model_step();
    bit raw [3];
    bit press [3];
    bit held [3];
    bit pw, both, cand, act, is_set;
    int nx, k;
    raw[0] = mode_btn; raw[1] = up_btn; raw[2] = down_btn;
    m_n++;
    pw = m_psamp[1];
    for (int b = 0; b < 3; b++) begin
      held[b]  = m_db[b];
      press[b] = (m_rise[b] == m_n - 1);
      if (m_bsamp[b][1] != m_db[b]) begin
        m_streak[b]++;
        if (m_streak[b] == D) begin
          m_db[b] = ~m_db[b];
          m_streak[b] = 0;
          if (m_db[b]) m_rise[b] = m_n;
        end
      end else begin
        m_streak[b] = 0;
      end
      m_bsamp[b][1] = m_bsamp[b][0];
      m_bsamp[b][0] = raw[b];
    end
    m_psamp[1] = m_psamp[0];
    m_psamp[0] = power;
    both = held[1] && held[2];
    cand = 0;
    if (m_rdir != 0 && !both && held[m_rdir]) begin
      k = m_n - m_t0;
      if (k >= RD && (k - RD) % RR == 0) cand = 1;
    end
    is_set = (m_st >= 2 && m_st <= 6);
    act = press[0] || press[1] || press[2] || cand;
    if (!pw) nx = 0;
    else if (m_st == 0) nx = 1;
    else if (press[0]) nx = (m_st == 6) ? 1 : m_st + 1;
    else if (is_set && (m_n - m_last) >= TO && !act) nx = 1;
    else nx = m_st;
    e_add = '0;
    e_sub = '0;
    if (nx != m_st || !is_set || both) begin
      m_rdir = 0;
    end else if (press[1]) begin
      e_add = fld_of(m_st); m_rdir = 1; m_t0 = m_n;
    end else if (press[2]) begin
      e_sub = fld_of(m_st); m_rdir = 2; m_t0 = m_n;
    end else if (cand) begin
      if (m_rdir == 1) e_add = fld_of(m_st);
      else             e_sub = fld_of(m_st);
    end
    if (nx != m_st || act) m_last = m_n;
    m_st = nx;
  endtask

  task automatic tick();
    @(posedge clk_src);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_src);
    #1;
    n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b want 0", enable); end
    n_cmp++; if (add_time !== 3'b0) begin n_fail++; $display("FAIL reset_add: got %b want 000", add_time); end
    n_cmp++; if (sub_time !== 3'b0) begin n_fail++; $display("FAIL reset_sub: got %b want 000", sub_time); end
    n_cmp++; if (timing_clock_switch !== 1'b0) begin n_fail++; $display("FAIL reset_tcs: got %b want 0", timing_clock_switch); end
    n_cmp++; if (field_sel !== 3'b0) begin n_fail++; $display("FAIL reset_field: got %b want 000", field_sel); end
    reset_n = 1'b1;
  endtask

  task automatic test_power_on();
    power = 1'b1;
    tick(); tick();
    n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL pwr_on_early: got %0d want 0", state); end
    tick();
    n_cmp++; if (state !== 3'd1) begin n_fail++; $display("FAIL pwr_on_state: got %0d want 1", state); end
    n_cmp++; if (enable !== 1'b1) begin n_fail++; $display("FAIL pwr_on_enable: got %b want 1", enable); end
    n_cmp++; if ((add_time | sub_time) !== 3'b0) begin n_fail++; $display("FAIL pwr_on_pulses: got %b/%b want 0", add_time, sub_time); end
  endtask

  task automatic test_mode();
    mode_btn = 1'b1;
    repeat (6) tick();
    n_cmp++; if (state !== 3'd1) begin n_fail++; $display("FAIL mode1_early: got %0d want 1", state); end
    tick();
    n_cmp++; if (state !== 3'd2) begin n_fail++; $display("FAIL mode1_state: got %0d want 2", state); end
    n_cmp++; if (enable !== 1'b0) begin n_fail++; $display("FAIL mode1_enable: got %b want 0", enable); end
    n_cmp++; if (field_sel !== 3'b100) begin n_fail++; $display("FAIL mode1_field: got %b want 100", field_sel); end
    repeat (3) tick();
    mode_btn = 1'b0;
    repeat (10) tick();
    mode_btn = 1'b1;
    repeat (7) tick();
    n_cmp++; if (state !== 3'd3) begin n_fail++; $display("FAIL mode2_state: got %0d want 3", state); end
    n_cmp++; if (field_sel !== 3'b010) begin n_fail++; $display("FAIL mode2_field: got %b want 010", field_sel); end
    repeat (3) tick();
    mode_btn = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_repeat();
    int first = -1;
    int offs[$];
    int exp_offs [7];
    bit bad_val = 0;
    exp_offs = '{0, 16, 20, 24, 28, 32, 36};
    up_btn = 1'b1;
    for (int t = 1; t <= 50; t++) begin
      tick();
      if (add_time != 3'b0) begin
        if (first < 0) first = t;
        offs.push_back(t - first);
        if (add_time !== 3'b010) bad_val = 1;
      end
      if (sub_time != 3'b0) bad_val = 1;
      if (t == 40) up_btn = 1'b0;
    end
    n_cmp++; if (first !== 7) begin n_fail++; $display("FAIL rpt_first: got tick %0d want 7", first); end
    n_cmp++; if (offs.size() !== 7) begin n_fail++; $display("FAIL rpt_count: got %0d want 7", offs.size()); end
    if (offs.size() == 7) begin
      for (int i = 0; i < 7; i++) begin
        n_cmp++;
        if (offs[i] !== exp_offs[i]) begin
          n_fail++; $display("FAIL rpt_offset%0d: got %0d want %0d", i, offs[i], exp_offs[i]);
        end
      end
    end
    n_cmp++; if (bad_val !== 1'b0) begin n_fail++; $display("FAIL rpt_value: got wrong pulse bit want 010 only"); end
    n_cmp++; if (state !== 3'd3) begin n_fail++; $display("FAIL rpt_state: got %0d want 3", state); end
  endtask

  task automatic test_timeout();
    mode_btn = 1'b1;
    repeat (7) tick();
    n_cmp++; if (state !== 3'd4) begin n_fail++; $display("FAIL to_enter: got %0d want 4", state); end
    repeat (3) tick();
    mode_btn = 1'b0;
    repeat (90) tick();
    mode_btn = 1'b1;
    repeat (3) tick();
    mode_btn = 1'b0;
    repeat (20) tick();
    n_cmp++; if (state !== 3'd4) begin n_fail++; $display("FAIL glitch_ignored: got %0d want 4", state); end
    repeat (262 - 123) tick();
    n_cmp++; if (state !== 3'd4) begin n_fail++; $display("FAIL to_early: got %0d want 4", state); end
    tick();
    n_cmp++; if (state !== 3'd1) begin n_fail++; $display("FAIL to_state: got %0d want 1", state); end
    n_cmp++; if (enable !== 1'b1) begin n_fail++; $display("FAIL to_enable: got %b want 1", enable); end
    n_cmp++; if (field_sel !== 3'b0) begin n_fail++; $display("FAIL to_field: got %b want 000", field_sel); end
  endtask

  task automatic test_alarm();
    int cnt = 0;
    for (int p = 0; p < 4; p++) begin
      mode_btn = 1'b1; repeat (10) tick();
      mode_btn = 1'b0; repeat (10) tick();
    end
    n_cmp++; if (state !== 3'd5) begin n_fail++; $display("FAIL alm_state: got %0d want 5", state); end
    up_btn = 1'b1;
    down_btn = 1'b1;
    repeat (30) begin
      tick();
      if (add_time != 3'b0 || sub_time != 3'b0) cnt++;
    end
    n_cmp++; if (cnt !== 0) begin n_fail++; $display("FAIL alm_both_pulses: got %0d want 0", cnt); end
    n_cmp++; if (timing_clock_switch !== 1'b1) begin n_fail++; $display("FAIL alm_tcs: got %b want 1", timing_clock_switch); end
    n_cmp++; if (field_sel !== 3'b100) begin n_fail++; $display("FAIL alm_field: got %b want 100", field_sel); end
    n_cmp++; if (state !== 3'd5) begin n_fail++; $display("FAIL alm_hold_state: got %0d want 5", state); end
    up_btn = 1'b0;
    down_btn = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_power_drop();
    int cnt = 0;
    for (int p = 0; p < 3; p++) begin
      mode_btn = 1'b1; repeat (10) tick();
      mode_btn = 1'b0; repeat (10) tick();
    end
    n_cmp++; if (state !== 3'd2) begin n_fail++; $display("FAIL pd_seth: got %0d want 2", state); end
    power = 1'b0;
    tick(); tick();
    n_cmp++; if (state !== 3'd2) begin n_fail++; $display("FAIL pd_early: got %0d want 2", state); end
    tick();
    n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL pd_state: got %0d want 0", state); end
    n_cmp++; if (field_sel !== 3'b0) begin n_fail++; $display("FAIL pd_field: got %b want 000", field_sel); end
    repeat (2) begin
      up_btn = 1'b1;
      repeat (10) begin tick(); if (add_time != 3'b0 || state != 3'd0) cnt++; end
      up_btn = 1'b0;
      repeat (10) begin tick(); if (add_time != 3'b0 || state != 3'd0) cnt++; end
    end
    n_cmp++; if (cnt !== 0) begin n_fail++; $display("FAIL pd_up_ignored: got %0d events want 0", cnt); end
    power = 1'b1;
    tick(); tick();
    n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL pr_early: got %0d want 0", state); end
    tick();
    n_cmp++; if (state !== 3'd1) begin n_fail++; $display("FAIL pr_state: got %0d want 1", state); end
    n_cmp++; if (enable !== 1'b1) begin n_fail++; $display("FAIL pr_enable: got %b want 1", enable); end
  endtask

  task automatic test_reset_mid();
    mode_btn = 1'b1; repeat (10) tick();
    mode_btn = 1'b0; repeat (10) tick();
    up_btn = 1'b1;
    repeat (12) tick();
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL rstmid_state: got %0d want 0", state); end
    n_cmp++; if (field_sel !== 3'b0) begin n_fail++; $display("FAIL rstmid_field: got %b want 000", field_sel); end
    n_cmp++; if ({enable, timing_clock_switch, add_time, sub_time} !== 8'b0) begin
      n_fail++; $display("FAIL rstmid_outs: got %b want 0", {enable, timing_clock_switch, add_time, sub_time});
    end
    model_reset();
    up_btn = 1'b0;
    @(posedge clk_src);
    @(posedge clk_src);
    #1 reset_n = 1'b1;
    tick(); tick();
    n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL rstmid_early: got %0d want 0", state); end
    tick();
    n_cmp++; if (state !== 3'd1) begin n_fail++; $display("FAIL rstmid_run: got %0d want 1", state); end
  endtask

  task automatic test_random();
    int   rem [4];
    logic lv;
    for (int i = 0; i < 4; i++) rem[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (rem[i] == 0) begin
          lv = 1'($urandom_range(0, 1));
          rem[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 320))
                                                : int'($urandom_range(1, 24));
          case (i)
            0:       mode_btn = lv;
            1:       up_btn = lv;
            default: down_btn = lv;
          endcase
        end
        rem[i]--;
      end
      if (rem[3] == 0) begin
        if (power && $urandom_range(0, 3) == 0) begin
          power = 1'b0; rem[3] = int'($urandom_range(1, 12));
        end else begin
          power = 1'b1; rem[3] = int'($urandom_range(40, 600));
        end
      end
      rem[3]--;
      tick();
      n_cmp++; if (state !== 3'(m_st)) begin n_fail++; $display("FAIL rnd_state @%0d: got %0d want %0d", c, state, m_st); end
      n_cmp++; if (enable !== (m_st == 1)) begin n_fail++; $display("FAIL rnd_enable @%0d: got %b want %b", c, enable, m_st == 1); end
      n_cmp++; if (timing_clock_switch !== (m_st == 5 || m_st == 6)) begin
        n_fail++; $display("FAIL rnd_tcs @%0d: got %b want %b", c, timing_clock_switch, m_st == 5 || m_st == 6);
      end
      n_cmp++; if (field_sel !== fld_of(m_st)) begin n_fail++; $display("FAIL rnd_field @%0d: got %b want %b", c, field_sel, fld_of(m_st)); end
      n_cmp++; if (add_time !== e_add) begin n_fail++; $display("FAIL rnd_add @%0d: got %b want %b", c, add_time, e_add); end
      n_cmp++; if (sub_time !== e_sub) begin n_fail++; $display("FAIL rnd_sub @%0d: got %b want %b", c, sub_time, e_sub); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_power_on();
    test_mode();
    test_repeat();
    test_timeout();
    test_alarm();
    test_power_drop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
